// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop sync, 3-sample majority vote per bit, FWFT status FIFO.
// Entry visible two cycles after the final stop vote; no line backpressure, a full FIFO drops the frame and sets overrun.
module uart_rx_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              baudrate,
  input  logic [1:0]                    data_len,
  input  logic [1:0]                    parity_sel,
  input  logic                          stop_sel,
  input  logic                          rxd,
  input  logic                          ren,
  input  logic                          ovr_clr,
  output logic [7:0]                    rdata,
  output logic                          rframe_err,
  output logic                          rparity_err,
  output logic                          rbreak,
  output logic                          rvalid,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t state, state_nxt;

  logic             sync1, sync2, rx_prev, rx_s;
  logic [DIV_W-1:0] baud_q, cnt, mid;
  logic [1:0]       dlen_q, par_q;
  logic             stop_q;
  logic             samp_a, samp_b, vote;
  logic             at_m1, at_mid, at_p1, wrap;
  logic [3:0]       bit_cnt, nbits;
  logic             stop_idx, last_stop;
  logic [7:0]       shreg;
  logic             par_acc, seen_one, stop_bad;
  logic             par_en, brk_det;

  logic             frame_end;
  logic [7:0]       ent_data;
  logic             ent_fe, ent_pe, ent_brk;
  logic             push_pend;
  logic [10:0]      ent_q;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign rx_s      = sync2;
  assign mid       = baud_q >> 1;
  assign at_m1     = (cnt == mid - ONE);
  assign at_mid    = (cnt == mid);
  assign at_p1     = (cnt == mid + ONE);
  assign wrap      = (cnt == baud_q);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign nbits     = {2'b00, dlen_q} + 4'd5;
  assign last_stop = (stop_idx == stop_q);
  assign par_en    = par_q[0] ^ par_q[1];
  assign brk_det   = ~seen_one & ~vote;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (rx_prev && !rx_s) state_nxt = START;
      START:    if (at_p1 && vote) state_nxt = IDLE;
                else if (wrap) state_nxt = DATA;
      DATA:     if (wrap && bit_cnt == nbits) state_nxt = par_en ? PARITY : STOP;
      PARITY:   if (wrap) state_nxt = STOP;
      STOP:     if (at_p1 && last_stop) state_nxt = brk_det ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rx_s && wrap) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Entry is formed on the last stop vote; break overrides data and flags.
  always_comb begin
    frame_end = (state == STOP) && at_p1 && last_stop;
    ent_brk   = brk_det;
    ent_fe    = brk_det | stop_bad | ~vote;
    ent_pe    = par_en & ~brk_det & (par_acc ^ par_q[1]);
    ent_data  = brk_det ? 8'h00 : (shreg >> (2'd3 - dlen_q));
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      baud_q    <= '0;
      dlen_q    <= '0;
      par_q     <= '0;
      stop_q    <= 1'b0;
      cnt       <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      bit_cnt   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      seen_one  <= 1'b0;
      stop_bad  <= 1'b0;
      push_pend <= 1'b0;
      ent_q     <= '0;
    end else begin
      push_pend <= frame_end;
      if (frame_end) ent_q <= {ent_data, ent_fe, ent_pe, ent_brk};

      if (state == IDLE) begin
        baud_q <= baudrate;
        dlen_q <= data_len;
        par_q  <= parity_sel;
        stop_q <= stop_sel;
      end

      if (state == IDLE || state_nxt != state) cnt <= '0;
      else if (state == BRK_WAIT && !rx_s)    cnt <= '0;
      else if (wrap)                          cnt <= '0;
      else                                    cnt <= cnt + ONE;

      if (at_m1)  samp_a <= rx_s;
      if (at_mid) samp_b <= rx_s;

      unique case (state)
        IDLE: begin
          bit_cnt  <= '0;
          stop_idx <= 1'b0;
          shreg    <= '0;
          par_acc  <= 1'b0;
          seen_one <= 1'b0;
          stop_bad <= 1'b0;
        end
        DATA: if (at_p1) begin
          shreg    <= {vote, shreg[7:1]};
          par_acc  <= par_acc ^ vote;
          seen_one <= seen_one | vote;
          bit_cnt  <= bit_cnt + 4'd1;
        end
        PARITY: if (at_p1) begin
          par_acc  <= par_acc ^ vote;
          seen_one <= seen_one | vote;
        end
        STOP: begin
          if (at_p1) begin
            stop_bad <= stop_bad | ~vote;
            seen_one <= seen_one | vote;
          end
          if (wrap) stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en, ovr_set;

  assign rvalid  = (level != '0);
  assign full    = (level == DEPTH_L);
  assign pop     = ren & rvalid;
  assign wr_en   = push_pend & (~full | pop);
  assign ovr_set = push_pend & full & ~pop;

  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_ptr] <= ent_q;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !wr_en) level <= level - (AW+1)'(1);
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign {rdata, rframe_err, rparity_err, rbreak} = rvalid ? mem[rd_ptr] : 11'd0;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at baudrate=15 with a 4-entry FIFO.
module tb_uart_rx_param;
  localparam int BAUD = 15;

  logic        mclk = 1'b0;
  logic        reset;
  logic [15:0] baudrate;
  logic [1:0]  data_len, parity_sel;
  logic        stop_sel, rxd, ren, ovr_clr;
  logic [7:0]  rdata;
  logic        rframe_err, rparity_err, rbreak, rvalid, overrun;
  logic [2:0]  level;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_param #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .mclk(mclk), .reset(reset), .baudrate(baudrate), .data_len(data_len),
    .parity_sel(parity_sel), .stop_sel(stop_sel), .rxd(rxd), .ren(ren),
    .ovr_clr(ovr_clr), .rdata(rdata), .rframe_err(rframe_err),
    .rparity_err(rparity_err), .rbreak(rbreak), .rvalid(rvalid),
    .overrun(overrun), .level(level)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Drives n bits LSB-first, each held one full bit period.
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      rxd = bits[i];
      repeat (BAUD) @(negedge mclk);
    end
  endtask

  task automatic wait_vld(input int budget);
    int k = 0;
    while (!rvalid && k < budget) begin
      @(negedge mclk);
      k++;
    end
  endtask

  task automatic expect_head(input string tag, input logic [7:0] d,
                             input logic fe, input logic pe, input logic brk);
    wait_vld(64);
    chk({tag, "_vld"}, rvalid, 1);
    chk({tag, "_dat"}, rdata, d);
    chk({tag, "_flg"}, {rframe_err, rparity_err, rbreak}, {fe, pe, brk});
  endtask

  task automatic pop();
    @(negedge mclk);
    ren = 1'b1;
    @(negedge mclk);
    ren = 1'b0;
  endtask

  logic [7:0] ob [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    reset = 1'b0; baudrate = 16'd15; data_len = 2'b11; parity_sel = 2'b00;
    stop_sel = 1'b0; rxd = 1'b1; ren = 1'b0; ovr_clr = 1'b0;
    idle(3);
    chk("rst_level", level, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {rframe_err, rparity_err, rbreak}, 0);
    reset = 1'b1;
    idle(5);

    // 8N1 0xA5
    send_bits({1'b1, 8'hA5, 1'b0}, 10);
    expect_head("a5", 8'hA5, 0, 0, 0);
    chk("a5_level", level, 1);
    pop();
    chk("a5_pop_level", level, 0);
    chk("a5_pop_rvalid", rvalid, 0);

    // 7E2 0x35 (four ones): wrong parity bit 1, then correct parity bit 0
    data_len = 2'b10; parity_sel = 2'b01; stop_sel = 1'b1;
    idle(4);
    send_bits({1'b1, 1'b1, 1'b1, 7'h35, 1'b0}, 11);
    expect_head("7e2_bad", 8'h35, 0, 1, 0);
    pop();
    send_bits({1'b1, 1'b1, 1'b0, 7'h35, 1'b0}, 11);
    expect_head("7e2_ok", 8'h35, 0, 0, 0);
    pop();

    // 7O1 0x35 with parity bit 1 is correct
    parity_sel = 2'b10; stop_sel = 1'b0;
    idle(4);
    send_bits({1'b1, 1'b1, 7'h35, 1'b0}, 10);
    expect_head("7o1_ok", 8'h35, 0, 0, 0);
    pop();

    // 5N1 0x1F with stop bit 0
    data_len = 2'b00; parity_sel = 2'b00;
    idle(4);
    send_bits({1'b0, 5'h1F, 1'b0}, 7);
    rxd = 1'b1;
    expect_head("5n1_fe", 8'h1F, 1, 0, 0);
    pop();

    // 4-cycle glitch is rejected, then a normal frame still works
    data_len = 2'b11;
    idle(20);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(60);
    chk("glitch_level", level, 0);
    chk("glitch_rvalid", rvalid, 0);
    send_bits({1'b1, 8'h3C, 1'b0}, 10);
    expect_head("post_glitch", 8'h3C, 0, 0, 0);
    chk("post_glitch_level", level, 1);
    pop();

    // Format is latched at frame start: data_len change mid-frame is ignored
    idle(4);
    send_bits(16'h0000, 1);
    data_len = 2'b00;
    send_bits({1'b1, 8'hC3}, 9);
    data_len = 2'b11;
    expect_head("cfg_hold", 8'hC3, 0, 0, 0);
    pop();

    // Break: 20 bit periods low yields exactly one break entry
    idle(4);
    rxd = 1'b0;
    idle(320);
    rxd = 1'b1;
    idle(48);
    chk("brk_level", level, 1);
    expect_head("brk", 8'h00, 1, 0, 1);
    pop();
    send_bits({1'b1, 8'h55, 1'b0}, 10);
    expect_head("post_brk", 8'h55, 0, 0, 0);
    chk("post_brk_level", level, 1);
    pop();

    // Overrun: 5 frames into a 4-deep FIFO
    idle(4);
    for (int i = 0; i < 5; i++) send_bits({1'b1, ob[i], 1'b0}, 10);
    idle(4);
    chk("ovr_level", level, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", rdata, 8'h11);
    @(negedge mclk);
    ovr_clr = 1'b1;
    @(negedge mclk);
    ovr_clr = 1'b0;
    chk("ovr_clr_flag", overrun, 0);
    chk("ovr_clr_level", level, 4);
    pop();
    chk("ovr_pop_level", level, 3);
    chk("ovr_pop_head", rdata, 8'h22);

    // Asynchronous reset takes effect before the next clock edge
    @(negedge mclk);
    #2 reset = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge mclk);
    reset = 1'b1;
    idle(4);

    // Reset mid-frame discards the partial frame
    send_bits({3'b101, 1'b0}, 4);
    @(negedge mclk);
    reset = 1'b0;
    rxd = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(200);
    chk("partial_level", level, 0);
    send_bits({1'b1, 8'h96, 1'b0}, 10);
    expect_head("post_partial", 8'h96, 0, 0, 0);
    chk("post_partial_level", level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
